uart_rx_packetizer: RTL and testbench

UART 8N1 receiver that turns the serial `uart_rx` pin into byte packets for the instruction loader. It synchronises and samples the line, validates the start and stop bits, and holds each good byte in a one-entry buffer. The byte is offered on `uart_packet`/`packet_ready` until the loader returns `packet_ack`. It sits directly upstream of the loader, between the board RX pin and the loader's `uart_packet`, `packet_ready` and `packet_ack` ports.

---
 rtl/uart_rx_packetizer.sv | 150 +++++++++++++++
 tb/tb_uart_rx_packetizer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_packetizer.sv
// uart_rx_packetizer
//   UART 8N1 receiver feeding the instruction loader. The serial line is
//   synchronised, start/data/stop bits are sampled mid-bit, and each good
//   byte is held in a one-entry buffer until the loader acknowledges it.
//
// Ports
//   clk            system clock, rising-edge active
//   rst_n          asynchronous active-low reset
//   uart_rx        asynchronous serial input, idles high
//   packet_ack     loader consumed the held byte (sampled on clk)
//   uart_packet    held byte, LSB received first
//   packet_ready   held byte is valid (level)
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun        one-cycle pulse: good byte dropped because buffer was full
module uart_rx_packetizer #(
   parameter int CLKS_PER_BIT = 868,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   input  logic       packet_ack,
   output logic [7:0] uart_packet,
   output logic       packet_ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } state_t;

   state_t        state;
   logic          rx_m;
   logic          rx_s;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;

   // Two-flop synchroniser; reset high so a reset never looks like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= uart_rx;
         rx_s <= rx_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         uart_packet   <= '0;
         packet_ready  <= 1'b0;
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;

         // Ack clears the buffer; a delivery on the same edge overrides this below.
         if (packet_ready && packet_ack) begin
            packet_ready <= 1'b0;
         end

         case (state)
            IDLE: begin
               cnt <= '0;
               if (!rx_s) begin
                  state <= START;
               end
            end

            START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     bit_idx <= '0;
                     state   <= DATA;
                  end else begin
                     state   <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state <= IDLE;
                     // Empty buffer, or full buffer being acked on this very edge.
                     if (!packet_ready || packet_ack) begin
                        uart_packet  <= shreg;
                        packet_ready <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     framing_error <= 1'b1;
                     state         <= WAIT_HIGH;
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end

            WAIT_HIGH: begin
               cnt <= '0;
               if (rx_s) begin
                  state <= IDLE;
               end
            end

            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_packetizer.sv
// tb_uart_rx_packetizer
//   Scoreboard bench for uart_rx_packetizer with CLKS_PER_BIT = 8.
//   Stimulus pushes expected events (byte delivery, framing error, overrun);
//   a monitor pops and compares whenever the DUT presents one.
module tb_uart_rx_packetizer;

   localparam int CPB = 8;

   localparam int EV_BYTE = 0;
   localparam int EV_FE   = 1;
   localparam int EV_OV   = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic       packet_ack;
   logic [7:0] uart_packet;
   logic       packet_ready;
   logic       framing_error;
   logic       overrun;

   int tests = 0;
   int fails = 0;

   typedef struct {
      int         kind;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];

   logic mon_prev_ready = 1'b0;
   logic mon_prev_ack   = 1'b0;

   always #5 clk = ~clk;

   uart_rx_packetizer #(
      .CLKS_PER_BIT(CPB),
      .HALF_BIT    (CPB / 2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .uart_rx      (uart_rx),
      .packet_ack   (packet_ack),
      .uart_packet  (uart_packet),
      .packet_ready (packet_ready),
      .framing_error(framing_error),
      .overrun      (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push(input int kind, input logic [7:0] d);
      exp_t e;
      e.kind = kind;
      e.data = d;
      exp_q.push_back(e);
   endtask

   // Called just after a rising edge; drives one full frame, returns just after a rising edge.
   task automatic send_frame(input logic [7:0] d, input logic stop_bit);
      uart_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      uart_rx = stop_bit;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic align;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_ack;
      packet_ack = 1'b1;
      @(posedge clk);
      #1;
      packet_ack = 1'b0;
   endtask

   // Loader behaviour: wait for ready (bounded), ack two cycles later, confirm the clear.
   task automatic loader_ack(input string name);
      for (int n = 0; n < 200 && !packet_ready; n++) @(negedge clk);
      chk({name, "_ready_seen"}, {31'd0, packet_ready}, 32'd1);
      align();
      align();
      pulse_ack();
      @(negedge clk);
      chk({name, "_ready_low_after_ack"}, {31'd0, packet_ready}, 32'd0);
   endtask

   // Monitor / scoreboard
   task automatic check_event(input int kind, input logic [7:0] d);
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL unexpected_event: got kind %0d data %02h, required none (t=%0t)",
                  kind, d, $time);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || (kind != EV_FE && e.data !== d)) begin
            fails++;
            $display("FAIL event_match: got kind %0d data %02h, required kind %0d data %02h (t=%0t)",
                     kind, d, e.kind, e.data, $time);
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            // New byte: ready rose, or stayed high across an ack edge (refill).
            if (packet_ready && (!mon_prev_ready || mon_prev_ack)) check_event(EV_BYTE, uart_packet);
            if (framing_error) check_event(EV_FE, uart_packet);
            if (overrun)       check_event(EV_OV, uart_packet);
         end
         mon_prev_ready = packet_ready;
         mon_prev_ack   = packet_ack;
      end
   end

   // Stimulus
   initial begin
      rst_n      = 1'b0;
      uart_rx    = 1'b1;
      packet_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_packet",       {24'd0, uart_packet},     32'h00);
      chk("reset_ready",        {31'd0, packet_ready},    32'd0);
      chk("reset_framing",      {31'd0, framing_error},   32'd0);
      chk("reset_overrun",      {31'd0, overrun},         32'd0);
      align();
      rst_n = 1'b1;
      repeat (4) align();

      // Single byte 0xA5, ready must rise exactly on the stop-sample edge (e79).
      push(EV_BYTE, 8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (78) @(posedge clk);
            @(negedge clk);
            chk("single_ready_before_stop", {31'd0, packet_ready}, 32'd0);
            @(negedge clk);
            chk("single_ready_at_stop", {31'd0, packet_ready}, 32'd1);
            chk("single_data_at_stop",  {24'd0, uart_packet},  32'hA5);
         end
      join
      repeat (10) align();
      chk("single_ready_held", {31'd0, packet_ready}, 32'd1);
      chk("single_data_held",  {24'd0, uart_packet},  32'hA5);
      pulse_ack();
      @(negedge clk);
      chk("single_ready_cleared", {31'd0, packet_ready}, 32'd0);
      chk("single_data_kept",     {24'd0, uart_packet},  32'hA5);
      align();

      // Loader sequence, back-to-back frames.
      push(EV_BYTE, 8'h00);
      push(EV_BYTE, 8'hF0);
      push(EV_BYTE, 8'hFF);
      fork
         begin
            send_frame(8'h00, 1'b1);
            send_frame(8'hF0, 1'b1);
            send_frame(8'hFF, 1'b1);
         end
         begin
            loader_ack("seq0");
            loader_ack("seq1");
            loader_ack("seq2");
         end
      join
      align();
      repeat (4) align();

      // Overrun: second byte dropped while the first is held.
      push(EV_BYTE, 8'h11);
      push(EV_OV,   8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      repeat (4) align();
      chk("overrun_data_kept",  {24'd0, uart_packet},  32'h11);
      chk("overrun_ready_held", {31'd0, packet_ready}, 32'd1);
      pulse_ack();
      @(negedge clk);
      chk("overrun_ready_cleared", {31'd0, packet_ready}, 32'd0);
      align();

      // Ack lands exactly on the second byte's stop-sample edge.
      push(EV_BYTE, 8'h11);
      push(EV_BYTE, 8'h22);
      send_frame(8'h11, 1'b1);
      fork
         send_frame(8'h22, 1'b1);
         begin
            repeat (78) @(posedge clk);
            #1;
            packet_ack = 1'b1;
            @(posedge clk);
            #1;
            packet_ack = 1'b0;
         end
      join
      repeat (2) align();
      chk("collide_ready", {31'd0, packet_ready}, 32'd1);
      chk("collide_data",  {24'd0, uart_packet},  32'h22);
      pulse_ack();
      @(negedge clk);
      chk("collide_ready_cleared", {31'd0, packet_ready}, 32'd0);
      align();

      // Two-cycle glitch: no events expected.
      uart_rx = 1'b0;
      repeat (2) align();
      uart_rx = 1'b1;
      repeat (20) align();
      chk("glitch_ready", {31'd0, packet_ready}, 32'd0);

      // Framing error followed by a long break, then a good frame.
      push(EV_FE, 8'h00);
      send_frame(8'h3C, 1'b0);
      repeat (40) align();
      uart_rx = 1'b1;
      repeat (10) align();
      chk("framing_ready_low", {31'd0, packet_ready}, 32'd0);
      push(EV_BYTE, 8'h3C);
      send_frame(8'h3C, 1'b1);
      repeat (4) align();
      chk("framing_next_data", {24'd0, uart_packet}, 32'h3C);
      pulse_ack();
      align();

      // Hold a byte, then reset mid-frame during data bit 4.
      push(EV_BYTE, 8'h77);
      send_frame(8'h77, 1'b1);
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (43) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #3;
            chk("midreset_packet",  {24'd0, uart_packet},   32'h00);
            chk("midreset_ready",   {31'd0, packet_ready},  32'd0);
            chk("midreset_framing", {31'd0, framing_error}, 32'd0);
            chk("midreset_overrun", {31'd0, overrun},       32'd0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
         end
      join
      repeat (4) align();
      push(EV_BYTE, 8'h5A);
      send_frame(8'h5A, 1'b1);
      repeat (4) align();
      chk("after_reset_ready", {31'd0, packet_ready}, 32'd1);
      chk("after_reset_data",  {24'd0, uart_packet},  32'h5A);
      pulse_ack();

      repeat (20) align();
      chk("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit, required completion");
      $fatal(1, "timeout");
   end

endmodule
